// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: MD_* op encodings and
// the IDLE/RUN view of the cycle counter.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO. Results are computed at
// accept time and held in pend_* until the emulated latency has elapsed.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic [31:0]      w_hi_nxt, w_lo_nxt, w_pend_hi_nxt, w_pend_lo_nxt;
  md_state_e        w_state;
  md_op_e           w_op;

  logic [63:0] w_ext_a, w_ext_b, w_prod;
  logic        w_div_signed, w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b, w_divisor, w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_op    = md_op_e'(i_op);
  assign w_state = (r_cnt == {CNT_W{1'b0}}) ? ST_IDLE : ST_RUN;

  // Sign- or zero-extending to 64 bits lets one truncated multiply serve MULT and MULTU.
  assign w_ext_a = (w_op == MD_MULT) ? {{32{i_src_a[31]}}, i_src_a} : {32'd0, i_src_a};
  assign w_ext_b = (w_op == MD_MULT) ? {{32{i_src_b[31]}}, i_src_b} : {32'd0, i_src_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Magnitude divide: truncation toward zero, remainder follows the dividend,
  // and 0x80000000 / -1 wraps naturally instead of overflowing a signed divide.
  assign w_div_signed = (w_op == MD_DIV);
  assign w_neg_a   = w_div_signed & i_src_a[31];
  assign w_neg_b   = w_div_signed & i_src_b[31];
  assign w_mag_a   = w_neg_a ? (32'd0 - i_src_a) : i_src_a;
  assign w_mag_b   = w_neg_b ? (32'd0 - i_src_b) : i_src_b;
  assign w_divisor = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q_mag   = w_mag_a / w_divisor;
  assign w_r_mag   = w_mag_a % w_divisor;
  assign w_quot    = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem     = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

  // Next-state logic: accept in IDLE, count down and write back in RUN.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    case (w_state)
      ST_IDLE: begin
        if (i_op_valid) begin
          case (w_op)
            MD_MULT, MD_MULTU: begin
              w_pend_hi_nxt = w_prod[63:32];
              w_pend_lo_nxt = w_prod[31:0];
              w_cnt_nxt     = CNT_W'(MULT_CYCLES);
            end
            MD_DIV, MD_DIVU: begin
              if (i_src_b == 32'd0) begin
                w_pend_hi_nxt = r_hi;
                w_pend_lo_nxt = r_lo;
              end else begin
                w_pend_hi_nxt = w_rem;
                w_pend_lo_nxt = w_quot;
              end
              w_cnt_nxt = CNT_W'(DIV_CYCLES);
            end
            MD_MTHI: w_hi_nxt = i_src_a;
            MD_MTLO: w_lo_nxt = i_src_a;
            default: w_cnt_nxt = r_cnt;
          endcase
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_hi_nxt = r_pend_hi;
          w_lo_nxt = r_pend_lo;
        end else begin
          w_hi_nxt = r_hi;
        end
      end
      default: w_cnt_nxt = {CNT_W{1'b0}};
    endcase
  end

  // State registers; reset abandons any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end
  end

  assign o_busy = (w_state == ST_RUN);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: each op pushes its expected HI/LO and
// busy length; the entry is popped and compared once busy drops.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_op_valid(op_valid),
    .i_op      (op),
    .i_src_a   (src_a),
    .i_src_b   (src_b),
    .o_busy    (busy),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  always #5 clk = ~clk;

  // Protocol monitor: the hazard unit must never present an op while busy.
  always @(posedge clk) begin
    if (!reset && op_valid && busy) begin
      viol <= viol + 1;
      $display("[TB] note: op_valid asserted while busy at %0t", $time);
    end
  end

  // Drive one op starting at a negedge, optionally poke an illegal MTHI at busy
  // cycle 'poke', then wait for busy to drop and check against the scoreboard.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                        input int poke, input string name);
    int   n;
    exp_t e;
    sb.push_back('{hi: ehi, lo: elo, cyc: ecyc});
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (poke != 0 && n == poke) begin
        op_valid = 1'b1; op = MD_MTHI; src_a = 32'hBAD0_BAD0;
      end else begin
        op_valid = 1'b0;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    e = sb.pop_front();
    tests++;
    if (n !== e.cyc) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, e.cyc);
    end
    tests++;
    if (hi !== e.hi) begin
      fails++;
      $display("FAIL %s hi: got %h expected %h", name, hi, e.hi);
    end
    tests++;
    if (lo !== e.lo) begin
      fails++;
      $display("FAIL %s lo: got %h expected %h", name, lo, e.lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    longint      ps;
    logic [63:0] pu;
    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0, "mult_neg");
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, 0, "multu");
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      ps = longint'($signed(a)) * longint'($signed(b));
      pu = {32'd0, a} * {32'd0, b};
      run_op(MD_MULT,  a, b, ps[63:32], ps[31:0], 5, 0, "mult_rand");
      run_op(MD_MULTU, a, b, pu[63:32], pu[31:0], 5, 0, "multu_rand");
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, "div_neg");
    run_op(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, 0, "divu");
    run_op(MD_DIV,  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 0, "div_negdivisor");
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom_range(1, 1000);
      run_op(MD_DIVU, a, b, a % b, a / b, 10, 0, "divu_rand");
    end
  endtask

  task automatic test_div_edge();
    run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0, "div_wrap");
    run_op(MD_MTHI, 32'h11, 32'd0, 32'h11, 32'h8000_0000, 0, 0, "pre_mthi");
    run_op(MD_MTLO, 32'h22, 32'd0, 32'h11, 32'h22, 0, 0, "pre_mtlo");
    run_op(MD_DIVU, 32'd1234, 32'd0, 32'h11, 32'h22, 10, 0, "divu_by_zero");
    run_op(MD_DIV,  32'hFFFF_0000, 32'd0, 32'h11, 32'h22, 10, 0, "div_by_zero");
  endtask

  task automatic test_mt();
    run_op(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'h22, 0, 0, "mthi");
    run_op(MD_MTLO, 32'h1234, 32'd0, 32'hDEAD_BEEF, 32'h1234, 0, 0, "mtlo");
  endtask

  task automatic test_reset_abort();
    op_valid = 1'b1; op = MD_MULT; src_a = 32'd1000; src_b = 32'd1000;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL abort_reset: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
        fails++;
        $display("FAIL abort_no_writeback: cycle %0d got busy=%b hi=%h lo=%h expected 0/0/0",
                 i, busy, hi, lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = viol;
    run_op(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5, 0, "b2b_mult");
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, 3, "b2b_divu_poked");
    tests++;
    if (viol - v0 !== 1) begin
      fails++;
      $display("FAIL busy_violation_flag: got %0d expected 1", viol - v0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_mt();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle multiply/divide unit in the EX stage. Consumes the operand pair and decoded op that the ID/EX pipeline register presents, and owns the architectural HI/LO registers. Drives busy back to the hazard unit so decode stalls any further mult/div/mfhi/mflo while an operation is in flight. Emulates the fixed MIPS latencies: 5 cycles for multiply, 10 cycles for divide.

Parameters:
MULT_CYCLES, 5, cycles busy is held high after a multiply is accepted
DIV_CYCLES, 10, cycles busy is held high after a divide is accepted

Ports:
clk  input  1  clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
op_valid  input  1  EX-stage instruction is a mult/div/mthi/mtlo and is not a bubble
op  input  3  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
src_a  input  32  rs value, already forwarded
src_b  input  32  rt value, already forwarded
busy  output  1  operation in flight; HI/LO not yet final
hi  output  32  HI register, read by mfhi
lo  output  32  LO register, read by mflo

Behaviour:
- Reset, synchronous on clk: busy=0, hi=0, lo=0, counter=0, pending results cleared.
- Reset mid-operation aborts the operation. HI/LO never receive the pending result.
- States: IDLE (counter==0, busy=0) and RUN (counter!=0, busy=1). busy is a decode of counter.
- Accept condition: op_valid && !busy at a rising edge.
- op_valid while busy: ignored, no state change. The hazard unit guarantees this never happens; the bench asserts it.
- MULT/MULTU accepted:
  - {pend_hi, pend_lo} is loaded with the 64-bit product, signed or unsigned.
  - counter is loaded with MULT_CYCLES.
- DIV/DIVU accepted:
  - pend_lo is loaded with the quotient and pend_hi with the remainder.
  - counter is loaded with DIV_CYCLES.
- RUN: counter decrements each edge. On the edge where counter==1, hi<=pend_hi, lo<=pend_lo and counter goes to 0.
- Timing: busy is high for exactly N cycles after the accepting edge. The new hi/lo are visible in the first cycle busy is low.
- MTHI/MTLO accepted: hi (or lo) <= src_a at the accepting edge. busy stays 0. The other register is unchanged. Value is visible next cycle.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000 (wrap, no trap).
- Divide by zero (src_b==0): the unit still goes busy for DIV_CYCLES, then HI/LO are left unchanged (pend_* is loaded with the current hi/lo). No exception.
- A new op may be accepted in the same cycle busy first reads 0.
- hi/lo are registered outputs. No combinational path from the inputs to hi, lo or busy.

Decomposition:
- MD_* op encodings (3-bit) live in the shared constant.vh, next to PC_START, and are also used by the decoder.
- The ID-stage mapping from instr_code to MD_* lives in instr.vh.
- No sub-module. The signed/unsigned product and quotient are inferred operators inside this block; the cycle count is emulated.

Test Plan:
1. MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
2. DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
3. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU x/0 with hi=0x11, lo=0x22 beforehand -> busy 10 cycles, hi/lo stay 0x11/0x22.
4. MTHI 0xDEADBEEF -> next cycle hi=0xDEADBEEF, lo unchanged, busy never asserted. MTLO 0x1234 immediately after -> lo=0x1234.
5. MULT accepted; reset asserted on the 3rd busy cycle -> next cycle busy=0, hi=lo=0. No late write-back appears over the following 5 cycles.
6. Back-to-back: MULT 6*7, then DIVU 100/7 presented in the first cycle busy is low -> hi/lo=0/42, then 10 busy cycles, then lo=14, hi=2. op_valid pulsed mid-busy -> ignored and flagged by the assertion.
